noc_traffic_gen: RTL and testbench
==================================

Name: noc_traffic_gen

Overview:
Synthesizable per-node packet injector that drives one router's local input port in the mesh and replaces hand-written flit stimulus. It emits configurable bursts of wormhole packets (HEAD/BODY/TAIL or HEADTAIL) to a programmed destination. VCs are picked round-robin among allocatable ones, and the block honours per-VC on/off flow control. It supports counted and continuous modes, inter-packet gaps and sequence-numbered payloads, so a sink checker can verify order and integrity.

Parameters:
MESH_SIZE_X, 2, mesh columns; sets the width of x_dest_i.
MESH_SIZE_Y, 3, mesh rows; sets the width of y_dest_i.
PKT_LEN_MAX, 8, maximum flits per packet, must be at least 1.
CNT_W, 16, width of the packet and flit counters.
GAP_CYCLES, 0, idle cycles inserted after each TAIL/HEADTAIL before the next HEAD.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start_i  in  1  one-cycle pulse that starts a burst; ignored while busy_o=1
stop_i  in  1  pulse: finish the current packet, then go to DONE
x_dest_i  in  DEST_ADDR_SIZE_X  destination x; latched on start
y_dest_i  in  DEST_ADDR_SIZE_Y  destination y; latched on start
pkt_len_i  in  $clog2(PKT_LEN_MAX+1)  flits per packet; latched on start; 0 is treated as 1
num_pkts_i  in  CNT_W  packets per burst; 0 means continuous until stop_i
is_on_off_i  in  VC_NUM  per-VC on/off from the router's local input (1 = may send)
is_allocatable_i  in  VC_NUM  per-VC free for a new packet (from the router)
data_o  out  flit_t  flit to the router's local data_i
is_valid_o  out  1  flit valid
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse at burst end
pkt_cnt_o  out  CNT_W  packets fully sent in the current burst
flit_cnt_o  out  CNT_W  flits sent in the current burst

Behaviour:
- Reset: state=IDLE. is_valid_o, busy_o, done_o, pkt_cnt_o, flit_cnt_o, data_o and the RR pointer are all 0. A reset asserted mid-packet aborts immediately; no TAIL is sent.
- All outputs are registered. A flit is issued at edge k when its condition holds on the inputs sampled at edge k; is_valid_o/data_o are then visible for exactly one cycle after edge k.
- FSM states: IDLE, HEAD, BODY, GAP, DONE.
- IDLE:
  - On start_i: latch dest/len/num, clear both counters, go to HEAD.
  - Head can be issued at the edge after the start edge at earliest.
- HEAD:
  - Candidate VC = first v, searched round-robin from rr_ptr, with is_allocatable_i[v] && is_on_off_i[v].
  - If none: stall with is_valid_o=0.
  - Else issue a flit with vc_id=v; x_dest/y_dest latched; head_pl = pkt_cnt (zero-extended or truncated).
  - Label is HEADTAIL if len=1, else HEAD.
  - Lock VC v; rr_ptr = v+1 mod VC_NUM.
  - Next state: BODY if len>1, else end-of-packet handling.
- BODY:
  - Issue a flit only when is_on_off_i[locked v]=1; otherwise stall (valid=0, index held).
  - bt_pl = {pkt_cnt low half, flit index low half}.
  - Label is BODY for index 1..len-2 and TAIL for index len-1.
  - is_allocatable_i is ignored here.
- End of packet (after TAIL/HEADTAIL):
  - pkt_cnt++.
  - Go to DONE if stop was pending, or if num!=0 and pkt_cnt+1==num.
  - Otherwise go to GAP if GAP_CYCLES>0, else HEAD.
  - In the non-stall case, back-to-back packets are legal with GAP_CYCLES=0.
- GAP: count GAP_CYCLES idle cycles, then go to HEAD. stop_i seen in GAP goes to DONE directly.
- DONE: done_o=1 for one cycle, then IDLE. Counters hold until the next start.
- stop_i handling:
  - Sets a sticky stop_pend flag, cleared on entering IDLE.
  - stop_i in HEAD with no flit yet issued goes to DONE without sending.
  - stop_i in IDLE is ignored.
- Counters: flit_cnt_o increments per issued flit. Both counters wrap modulo 2^CNT_W in continuous mode.
- Simultaneous events:
  - start_i with rst: reset wins.
  - start_i in DONE: ignored.
  - stop_i on the TAIL edge: packet completes, then DONE.

Decomposition:
- noc_params holds flit_t, flit_label_t, VC_NUM, DEST_ADDR_SIZE_X/Y, HEAD_PAYLOAD_SIZE and FLIT_DATA_SIZE.
- A new shared enum tg_state_t (IDLE, HEAD, BODY, GAP, DONE) is added to noc_params.
- One sub-module: rr_vc_picker. Inputs are the eligible vector and rr_ptr; outputs are grant_valid and grant_idx. It is combinational, and the pointer register lives in the parent.

Test Plan:
- Single HEADTAIL: start, len=1, num=1, dest (1,2), all VCs on/alloc -> one HEADTAIL on VC0 the cycle after start; done_o 2 cycles later; pkt_cnt_o=1, flit_cnt_o=1.
- 2-flit packet: len=2, num=1, dest (1,2) -> HEAD (x=1, y=2, pl=0) then TAIL on consecutive cycles, same vc_id; flit_cnt_o=2.
- Flow-control stall: len=4, drop is_on_off_i[VC0] for 3 cycles after HEAD -> valid=0 for 3 cycles, then BODY, BODY, TAIL on VC0 with indices 1, 2, 3 and no gaps or duplicates.
- VC round robin: num=3, len=2, VC_NUM VCs all allocatable -> heads on VC0, VC1, VC2 (mod VC_NUM). Then set is_allocatable_i=0 -> head stalls with valid=0 until re-enabled.
- Continuous with gap: num=0, GAP_CYCLES=2, len=3; stop_i mid-BODY of packet 4 -> packet 4 completes with TAIL; exactly 2 idle cycles between packets; pkt_cnt_o=4 with done_o.
- Reset mid-packet: rst during BODY of len=5 -> next cycle valid=0, busy_o=0, counters 0; a new start sends a fresh HEAD with head_pl=0.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types: flit format, VC count, destination widths and traffic-generator states.
package noc_params;

    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 1;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
    localparam int BT_HALF           = FLIT_DATA_SIZE / 2;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef enum logic [2:0] {TG_IDLE, TG_HEAD, TG_BODY, TG_GAP, TG_DONE} tg_state_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

    function automatic logic [VC_SIZE-1:0] vc_add(input logic [VC_SIZE-1:0] v, input int off);
        return VC_SIZE'((int'(v) + off) % VC_NUM);
    endfunction

endpackage

// File: rtl/rr_vc_picker.sv
// Round-robin VC picker: first eligible VC at or after rr_ptr.
// Latency: combinational, zero cycles.
// Backpressure: none; grant_valid=0 when no VC is eligible.
module rr_vc_picker
    import noc_params::*;
(
    input  logic [VC_NUM-1:0]  eligible,
    input  logic [VC_SIZE-1:0] rr_ptr,
    output logic               grant_valid,
    output logic [VC_SIZE-1:0] grant_idx
);

    logic [VC_SIZE-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // scan farthest-first so the nearest eligible VC overwrites and wins
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            cand = vc_add(rr_ptr, i);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node wormhole packet injector driving a router local input port.
// Latency: first HEAD one cycle after start; one flit per cycle when not stalled.
// Backpressure: HEAD waits for an allocatable+on VC, BODY/TAIL wait on the locked VC's on/off.
module noc_traffic_gen
    import noc_params::*;
#(
    parameter int MESH_SIZE_X = 2,
    parameter int MESH_SIZE_Y = 3,
    parameter int PKT_LEN_MAX = 8,
    parameter int CNT_W       = 16,
    parameter int GAP_CYCLES  = 0
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic                               stop_i,
    input  logic [DEST_ADDR_SIZE_X-1:0]        x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]        y_dest_i,
    input  logic [$clog2(PKT_LEN_MAX+1)-1:0]   pkt_len_i,
    input  logic [CNT_W-1:0]                   num_pkts_i,
    input  logic [VC_NUM-1:0]                  is_on_off_i,
    input  logic [VC_NUM-1:0]                  is_allocatable_i,
    output flit_t                              data_o,
    output logic                               is_valid_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [CNT_W-1:0]                   pkt_cnt_o,
    output logic [CNT_W-1:0]                   flit_cnt_o
);

    localparam int LEN_W = $clog2(PKT_LEN_MAX + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if ($clog2(MESH_SIZE_X) != DEST_ADDR_SIZE_X || $clog2(MESH_SIZE_Y) != DEST_ADDR_SIZE_Y) begin : g_mesh_chk
        $error("mesh size does not match noc_params destination widths");
    end
    if (PKT_LEN_MAX < 1) begin : g_len_chk
        $error("PKT_LEN_MAX must be at least 1");
    end

    tg_state_t                   state;
    tg_state_t                   eop_state;
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            idx_q;
    logic [CNT_W-1:0]            num_q;
    logic [VC_SIZE-1:0]          rr_ptr;
    logic [VC_SIZE-1:0]          vc_q;
    logic [GAP_W-1:0]            gap_cnt;
    logic                        stop_pend;
    logic                        stop_eff;
    logic                        last_pkt;
    logic                        body_last;
    logic [VC_NUM-1:0]           eligible;
    logic                        grant_valid;
    logic [VC_SIZE-1:0]          grant_idx;

    assign eligible  = is_allocatable_i & is_on_off_i;
    assign stop_eff  = stop_pend | stop_i;
    assign last_pkt  = (num_q != '0) && ((pkt_cnt_o + CNT_W'(1)) == num_q);
    assign body_last = (idx_q == (len_q - LEN_W'(1)));

    rr_vc_picker u_picker (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // where the FSM goes once the current packet's last flit is issued
    always_comb begin
        if (stop_eff || last_pkt) begin
            eop_state = TG_DONE;
        end else if (GAP_CYCLES > 0) begin
            eop_state = TG_GAP;
        end else begin
            eop_state = TG_HEAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TG_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            num_q      <= '0;
            rr_ptr     <= '0;
            vc_q       <= '0;
            gap_cnt    <= '0;
            stop_pend  <= 1'b0;
            data_o     <= '0;
            is_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pkt_cnt_o  <= '0;
            flit_cnt_o <= '0;
        end else begin
            is_valid_o <= 1'b0;
            done_o     <= 1'b0;
            if (state != TG_IDLE && stop_i) begin
                stop_pend <= 1'b1;
            end

            case (state)
                TG_IDLE: begin
                    if (start_i) begin
                        x_q        <= x_dest_i;
                        y_q        <= y_dest_i;
                        len_q      <= (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
                        num_q      <= num_pkts_i;
                        pkt_cnt_o  <= '0;
                        flit_cnt_o <= '0;
                        busy_o     <= 1'b1;
                        state      <= TG_HEAD;
                    end
                end

                TG_HEAD: begin
                    if (stop_eff) begin
                        state <= TG_DONE;
                    end else if (grant_valid) begin
                        is_valid_o                      <= 1'b1;
                        data_o.flit_label               <= (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
                        data_o.vc_id                    <= grant_idx;
                        data_o.data.head_data.x_dest    <= x_q;
                        data_o.data.head_data.y_dest    <= y_q;
                        data_o.data.head_data.head_pl   <= HEAD_PAYLOAD_SIZE'(pkt_cnt_o);
                        vc_q                            <= grant_idx;
                        rr_ptr                          <= vc_add(grant_idx, 1);
                        flit_cnt_o                      <= flit_cnt_o + CNT_W'(1);
                        idx_q                           <= LEN_W'(1);
                        if (len_q == LEN_W'(1)) begin
                            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
                            gap_cnt   <= '0;
                            state     <= eop_state;
                        end else begin
                            state <= TG_BODY;
                        end
                    end
                end

                TG_BODY: begin
                    // wormhole: the locked VC carries the rest, allocatability no longer matters
                    if (is_on_off_i[vc_q]) begin
                        is_valid_o        <= 1'b1;
                        data_o.flit_label <= body_last ? TAIL : BODY;
                        data_o.vc_id      <= vc_q;
                        data_o.data.bt_pl <= {BT_HALF'(pkt_cnt_o), BT_HALF'(idx_q)};
                        flit_cnt_o        <= flit_cnt_o + CNT_W'(1);
                        idx_q             <= idx_q + LEN_W'(1);
                        if (body_last) begin
                            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
                            gap_cnt   <= '0;
                            state     <= eop_state;
                        end
                    end
                end

                TG_GAP: begin
                    if (stop_eff) begin
                        state <= TG_DONE;
                    end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= TG_HEAD;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                TG_DONE: begin
                    done_o    <= 1'b1;
                    busy_o    <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= TG_IDLE;
                end

                default: state <= TG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Randomized bench for noc_traffic_gen: a packet-level reference model predicts every flit and stall.
module tb_noc_traffic_gen;
    import noc_params::*;

    localparam int PKT_LEN_MAX = 8;
    localparam int CNT_W       = 16;
    localparam int GAP_CYCLES  = 2;
    localparam int LEN_W       = $clog2(PKT_LEN_MAX + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start_i;
    logic                        stop_i;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i;
    logic [LEN_W-1:0]            pkt_len_i;
    logic [CNT_W-1:0]            num_pkts_i;
    logic [VC_NUM-1:0]           is_on_off_i;
    logic [VC_NUM-1:0]           is_allocatable_i;
    flit_t                       data_o;
    logic                        is_valid_o;
    logic                        busy_o;
    logic                        done_o;
    logic [CNT_W-1:0]            pkt_cnt_o;
    logic [CNT_W-1:0]            flit_cnt_o;

    noc_traffic_gen #(
        .MESH_SIZE_X (2),
        .MESH_SIZE_Y (3),
        .PKT_LEN_MAX (PKT_LEN_MAX),
        .CNT_W       (CNT_W),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .x_dest_i         (x_dest_i),
        .y_dest_i         (y_dest_i),
        .pkt_len_i        (pkt_len_i),
        .num_pkts_i       (num_pkts_i),
        .is_on_off_i      (is_on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .data_o           (data_o),
        .is_valid_o       (is_valid_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pkt_cnt_o        (pkt_cnt_o),
        .flit_cnt_o       (flit_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference state: round-robin start VC, packets and flits completed in this burst
    int         m_rr = 0;
    logic [CNT_W-1:0] m_pkt;
    logic [CNT_W-1:0] m_flit;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VC_NUM-1:0] rand_vec(input int pct);
        logic [VC_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < VC_NUM; i++) v[i] = (int'($urandom_range(99)) < pct);
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        x_dest_i = '0; y_dest_i = '0; pkt_len_i = '0; num_pkts_i = '0;
        is_on_off_i = '1; is_allocatable_i = '1;
        tick; tick;
        checks++;
        if (is_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, expected 0 0 0", is_valid_o, busy_o, done_o);
        end
        checks++;
        if (pkt_cnt_o !== '0 || flit_cnt_o !== '0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: pkt=%0d flit=%0d data=%h, expected all 0", pkt_cnt_o, flit_cnt_o, data_o);
        end
        start_i = 1'b1;
        tick;
        start_i = 1'b0; rst = 1'b0;
        tick;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b, expected 0", busy_o);
        end
        m_rr = 0;
    endtask

    // One burst: stop_mode 0=none, 1=stop in first BODY slot of packet stop_pkt, 2=stop in the gap after it
    task automatic test_burst(input string name, input int len, input int num, input int stop_mode,
                              input int stop_pkt, input int p_on, input int p_alloc);
        int eff_len, p, stalls, vc;
        bit fin, stop_sent;
        logic [VC_NUM-1:0] on, al, elig;
        logic [DEST_ADDR_SIZE_X-1:0] xd;
        logic [DEST_ADDR_SIZE_Y-1:0] yd;
        flit_label_t exp_lab;
        logic [FLIT_DATA_SIZE-1:0] exp_bt;

        eff_len = (len == 0) ? 1 : len;
        xd = DEST_ADDR_SIZE_X'($urandom_range(1));
        yd = DEST_ADDR_SIZE_Y'($urandom_range(2));
        start_i = 1'b1; x_dest_i = xd; y_dest_i = yd;
        pkt_len_i = LEN_W'(len); num_pkts_i = CNT_W'(num);
        tick;
        start_i = 1'b0; x_dest_i = ~xd; y_dest_i = ~yd;
        pkt_len_i = LEN_W'($urandom_range(PKT_LEN_MAX)); num_pkts_i = CNT_W'($urandom);
        checks++;
        if (busy_o !== 1'b1 || is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b valid=%b, expected busy=1 valid=0", name, busy_o, is_valid_o);
        end

        m_pkt = '0; m_flit = '0; p = 0; fin = 1'b0; stop_sent = 1'b0;
        while (!fin) begin
            stalls = 0;
            forever begin
                on = rand_vec(p_on); al = rand_vec(p_alloc);
                if (stalls > 20) begin on = '1; al = '1; end
                is_on_off_i = on; is_allocatable_i = al; elig = on & al;
                tick;
                if (elig != '0) break;
                stalls++;
                checks++;
                if (is_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s head_stall: valid=%b, expected 0 (no eligible VC)", name, is_valid_o);
                end
            end
            vc = -1;
            for (int i = 0; i < VC_NUM; i++)
                if (vc < 0 && elig[VC_SIZE'((m_rr + i) % VC_NUM)]) vc = (m_rr + i) % VC_NUM;
            exp_lab = (eff_len == 1) ? HEADTAIL : HEAD;
            checks++;
            if (is_valid_o !== 1'b1 || data_o.flit_label !== exp_lab || data_o.vc_id !== VC_SIZE'(vc) ||
                data_o.data.head_data.x_dest !== xd || data_o.data.head_data.y_dest !== yd ||
                data_o.data.head_data.head_pl !== HEAD_PAYLOAD_SIZE'(m_pkt)) begin
                errors++;
                $display("FAIL %s head pkt%0d: valid=%b label=%0d vc=%0d x=%0d y=%0d pl=%0d, expected 1 %0d %0d %0d %0d %0d",
                         name, p, is_valid_o, data_o.flit_label, data_o.vc_id, data_o.data.head_data.x_dest,
                         data_o.data.head_data.y_dest, data_o.data.head_data.head_pl,
                         exp_lab, vc, xd, yd, m_pkt);
            end
            m_rr = (vc + 1) % VC_NUM;
            m_flit++;

            for (int i = 1; i < eff_len; i++) begin
                stalls = 0;
                forever begin
                    on = rand_vec(p_on);
                    if (stalls > 20) on = '1;
                    is_on_off_i = on; is_allocatable_i = rand_vec(50);
                    start_i = ($urandom_range(3) == 0);
                    if (stop_mode == 1 && p == stop_pkt && i == 1 && !stop_sent) begin
                        stop_i = 1'b1; stop_sent = 1'b1;
                    end
                    tick;
                    stop_i = 1'b0; start_i = 1'b0;
                    if (on[VC_SIZE'(vc)]) break;
                    stalls++;
                    checks++;
                    if (is_valid_o !== 1'b0) begin
                        errors++;
                        $display("FAIL %s body_stall: valid=%b, expected 0 (VC%0d off)", name, is_valid_o, vc);
                    end
                end
                exp_lab = (i == eff_len - 1) ? TAIL : BODY;
                exp_bt  = {BT_HALF'(m_pkt), BT_HALF'(i)};
                checks++;
                if (is_valid_o !== 1'b1 || data_o.flit_label !== exp_lab || data_o.vc_id !== VC_SIZE'(vc) ||
                    data_o.data.bt_pl !== exp_bt) begin
                    errors++;
                    $display("FAIL %s body pkt%0d idx%0d: valid=%b label=%0d vc=%0d pl=%h, expected 1 %0d %0d %h",
                             name, p, i, is_valid_o, data_o.flit_label, data_o.vc_id, data_o.data.bt_pl,
                             exp_lab, vc, exp_bt);
                end
                m_flit++;
            end

            m_pkt++; p++;
            checks++;
            if (pkt_cnt_o !== m_pkt || flit_cnt_o !== m_flit) begin
                errors++;
                $display("FAIL %s counters: pkt=%0d flit=%0d, expected %0d %0d", name, pkt_cnt_o, flit_cnt_o, m_pkt, m_flit);
            end
            if (stop_sent || (num != 0 && p == num) || p > 200) begin
                fin = 1'b1;
            end else begin
                for (int g = 0; g < GAP_CYCLES; g++) begin
                    is_on_off_i = '1; is_allocatable_i = '1;
                    if (stop_mode == 2 && p - 1 == stop_pkt && g == 0) begin
                        stop_i = 1'b1; stop_sent = 1'b1;
                    end
                    tick;
                    stop_i = 1'b0;
                    checks++;
                    if (is_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                        errors++;
                        $display("FAIL %s gap%0d: valid=%b busy=%b, expected 0 1", name, g, is_valid_o, busy_o);
                    end
                    if (stop_sent) begin
                        fin = 1'b1;
                        break;
                    end
                end
            end
        end

        tick;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || is_valid_o !== 1'b0 || pkt_cnt_o !== m_pkt || flit_cnt_o !== m_flit) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b valid=%b pkt=%0d flit=%0d, expected 1 0 0 %0d %0d",
                     name, done_o, busy_o, is_valid_o, pkt_cnt_o, flit_cnt_o, m_pkt, m_flit);
        end
        tick;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b, expected 0 0", name, done_o, busy_o);
        end
    endtask

    task automatic test_stop_in_head;
        is_allocatable_i = '0; is_on_off_i = '1;
        start_i = 1'b1; pkt_len_i = LEN_W'(3); num_pkts_i = CNT_W'(2);
        tick;
        start_i = 1'b0;
        tick;
        checks++;
        if (is_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stop_head stall: valid=%b busy=%b, expected 0 1", is_valid_o, busy_o);
        end
        stop_i = 1'b1; is_allocatable_i = '1;
        tick;
        stop_i = 1'b0;
        checks++;
        if (is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_head no_send: valid=%b, expected 0", is_valid_o);
        end
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || pkt_cnt_o !== '0 || flit_cnt_o !== '0) begin
            errors++;
            $display("FAIL stop_head done: done=%b busy=%b pkt=%0d flit=%0d, expected 1 0 0 0",
                     done_o, busy_o, pkt_cnt_o, flit_cnt_o);
        end
        tick;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b done=%b, expected 0 0", busy_o, done_o);
        end
        stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_idle: busy=%b valid=%b, expected 0 0", busy_o, is_valid_o);
        end
    endtask

    task automatic test_reset_mid_packet;
        is_on_off_i = '1; is_allocatable_i = '1;
        start_i = 1'b1; pkt_len_i = LEN_W'(5); num_pkts_i = CNT_W'(1);
        tick;
        start_i = 1'b0;
        tick;
        tick;
        checks++;
        if (is_valid_o !== 1'b1 || data_o.flit_label !== BODY) begin
            errors++;
            $display("FAIL rst_mid setup: valid=%b label=%0d, expected 1 %0d", is_valid_o, data_o.flit_label, BODY);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (is_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || pkt_cnt_o !== '0 || flit_cnt_o !== '0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b busy=%b done=%b pkt=%0d flit=%0d, expected all 0",
                     is_valid_o, busy_o, done_o, pkt_cnt_o, flit_cnt_o);
        end
        m_rr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_burst("headtail",    1, 1, 0, 0, 100, 100);
        test_burst("two_flit",    2, 1, 0, 0, 100, 100);
        test_burst("fc_stall",    4, 1, 0, 0,  50, 100);
        test_burst("round_robin", 2, 3, 0, 0, 100, 100);
        test_burst("alloc_stall", 3, 2, 0, 0, 100,  25);
        test_burst("cont_stop",   3, 0, 1, 3, 100, 100);
        test_burst("stop_gap",    2, 0, 2, 1,  80,  80);
        test_burst("len_zero",    0, 2, 0, 0, 100, 100);
        test_stop_in_head;
        test_burst("after_stop",  5, 2, 0, 0,  70,  70);
        test_reset_mid_packet;
        test_burst("fresh_start", 5, 1, 0, 0, 100, 100);
        for (int r = 0; r < 6; r++)
            test_burst("random", $urandom_range(PKT_LEN_MAX), $urandom_range(4, 1), 0, 0,
                       $urandom_range(100, 40), $urandom_range(100, 40));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
